// File: rtl/ps2_key_decoder_if.sv
// Scan-code input and key-event output bundle for ps2_key_decoder.
// The slave modport is the decoder's view; master is the producer/consumer side.
interface ps2_key_decoder_if;
  logic       code_valid;
  logic [7:0] code_in;
  logic       code_err;
  logic [5:0] keys_held;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_key;
  logic       evt_release;
  logic [7:0] drop_cnt;

  modport slave (
    input  code_valid, code_in, code_err, evt_ready,
    output keys_held, evt_valid, evt_key, evt_release, drop_cnt
  );

  modport master (
    output code_valid, code_in, code_err, evt_ready,
    input  keys_held, evt_valid, evt_key, evt_release, drop_cnt
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder for six keys: tracks held keys and queues
// press/release events in a first-word-fall-through FIFO.
module ps2_key_decoder #(
  parameter int unsigned PREFIX_TIMEOUT = 2500000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic               CLK,
  input  logic               RST,
  ps2_key_decoder_if.slave   bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   tmo_q;
  logic [5:0]      held_q;
  logic [5:0]      held_d;

  logic [2:0]      key_mem_q [FIFO_DEPTH];
  logic            rel_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      drop_q;

  logic            is_ext;
  logic            is_brk;
  logic            accept;
  logic            is_e0;
  logic            is_f0;
  logic            hit;
  logic [2:0]      idx;
  logic            push;
  logic            push_rel;

  logic            fifo_valid;
  logic            fifo_full;
  logic            pop;
  logic            push_ok;
  logic            drop;

  // Byte classification and key-state update for the final byte of a sequence.
  always_comb begin
    is_ext   = (state_q == EXT) || (state_q == EXT_BRK);
    is_brk   = (state_q == BRK) || (state_q == EXT_BRK);
    accept   = bus.code_valid && !bus.code_err;
    is_e0    = (bus.code_in == 8'hE0);
    is_f0    = (bus.code_in == 8'hF0);
    hit      = 1'b0;
    idx      = '0;
    push     = 1'b0;
    push_rel = 1'b0;
    held_d   = held_q;

    if (is_ext) begin
      case (bus.code_in)
        8'h75: begin hit = 1'b1; idx = 3'd0; end
        8'h72: begin hit = 1'b1; idx = 3'd1; end
        8'h6B: begin hit = 1'b1; idx = 3'd2; end
        8'h74: begin hit = 1'b1; idx = 3'd3; end
        default: ;
      endcase
    end else begin
      case (bus.code_in)
        8'h29: begin hit = 1'b1; idx = 3'd4; end
        8'h5A: begin hit = 1'b1; idx = 3'd5; end
        default: ;
      endcase
    end

    if (accept && !is_e0 && !is_f0 && hit) begin
      if (!is_brk && !held_q[idx]) begin
        held_d[idx] = 1'b1;
        push        = 1'b1;
      end else if (is_brk && held_q[idx]) begin
        held_d[idx] = 1'b0;
        push        = 1'b1;
        push_rel    = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_valid = (cnt_q != '0);
    fifo_full  = (cnt_q == DEPTH_C);
    pop        = fifo_valid && bus.evt_ready;
    push_ok    = push && (!fifo_full || pop);
    drop       = push && fifo_full && !pop;
  end

  // Prefix FSM with idle timeout; keys_held updates regardless of FIFO space.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      held_q  <= '0;
    end else begin
      held_q <= held_d;
      if (bus.code_valid) begin
        tmo_q <= '0;
        if (bus.code_err) begin
          state_q <= IDLE;
        end else if (is_e0) begin
          state_q <= EXT;
        end else if (is_f0) begin
          case (state_q)
            IDLE:    state_q <= BRK;
            EXT:     state_q <= EXT_BRK;
            default: state_q <= state_q;
          endcase
        end else begin
          state_q <= IDLE;
        end
      end else if (state_q == IDLE) begin
        tmo_q <= '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_q   <= '0;
        state_q <= IDLE;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        key_mem_q[i] <= '0;
        rel_mem_q[i] <= 1'b0;
      end
    end else begin
      if (push_ok) begin
        key_mem_q[wr_q] <= idx;
        rel_mem_q[wr_q] <= push_rel;
        wr_q            <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (drop && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign bus.keys_held   = held_q;
  assign bus.evt_valid   = fifo_valid;
  assign bus.evt_key     = fifo_valid ? key_mem_q[rd_q] : '0;
  assign bus.evt_release = fifo_valid ? rel_mem_q[rd_q] : 1'b0;
  assign bus.drop_cnt    = drop_q;

endmodule
